// File: rtl/wb_stage_if.sv
// MEM-to-writeback handshake bundle: retiring instruction fields plus the load-data return path.
interface wb_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic [REG_W-1:0]  in_dest;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_valid;

  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_dest, in_alu_result,
    output mem_rdata, mem_rdata_valid,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg, in_dest, in_alu_result,
    input  mem_rdata, mem_rdata_valid,
    output in_ready
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for load data if needed, then
// drives a single-cycle register-bank write plus forwarding info and a retired counter.
module wb_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  wb_stage_if.slave         bus,
  output logic              reg_write,
  output logic [REG_W-1:0]  write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              busy,
  output logic [CNT_W-1:0]  retired_count
);

  typedef enum logic [1:0] {StIdle, StWaitMem, StCommit} state_e;

  state_e            state_q, state_d;
  logic              xfer;
  logic              hold_rw_q;
  logic [REG_W-1:0]  dest_q;
  logic [DATA_W-1:0] data_q;
  logic              reg_write_q;
  logic [REG_W-1:0]  write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              commit_rw_d;
  logic [REG_W-1:0]  commit_reg_d;
  logic [DATA_W-1:0] commit_data_d;

  assign bus.in_ready = reset_n & (state_q != StWaitMem);
  assign xfer         = bus.in_valid & bus.in_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StCommit: begin
        if (xfer) begin
          state_d = bus.in_mem_to_reg ? StWaitMem : StCommit;
        end else begin
          state_d = StIdle;
        end
      end
      StWaitMem: begin
        if (bus.mem_rdata_valid) begin
          state_d = StCommit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write-port values are computed one edge early so the bank sees plain flop outputs.
  always_comb begin
    commit_reg_d  = xfer ? bus.in_dest : dest_q;
    commit_data_d = xfer ? bus.in_alu_result : bus.mem_rdata;
    commit_rw_d   = (state_d == StCommit) & (xfer ? bus.in_reg_write : hold_rw_q);
    busy          = (state_q == StWaitMem);
    fwd_valid     = reg_write_q;
    fwd_reg       = dest_q;
    fwd_data      = data_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hold_rw_q    <= 1'b0;
      dest_q       <= '0;
      data_q       <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      cnt_q        <= '0;
    end else begin
      if (xfer) begin
        hold_rw_q <= bus.in_reg_write;
        dest_q    <= bus.in_dest;
        if (!bus.in_mem_to_reg) begin
          data_q <= bus.in_alu_result;
        end
      end else if (state_q == StWaitMem && bus.mem_rdata_valid) begin
        data_q <= bus.mem_rdata;
      end
      reg_write_q <= commit_rw_d;
      if (state_d == StCommit) begin
        write_reg_q  <= commit_reg_d;
        write_data_q <= commit_data_d;
      end
      // COMMIT is always exactly one cycle, so every cycle spent there is one retirement.
      if (state_q == StCommit) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign reg_write     = reg_write_q;
  assign write_reg     = write_reg_q;
  assign write_data    = write_data_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios then random transactions against a transaction-level model.
module tb_wb_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        fwd_valid;
  logic [2:0]  fwd_reg;
  logic [15:0] fwd_data;
  logic        busy;
  logic [3:0]  retired_count;

  int total = 0;
  int bad   = 0;

  // Model state: retirements since reset and the last committed write.
  int          exp_count = 0;
  logic [2:0]  last_reg  = '0;
  logic [15:0] last_data = '0;

  wb_stage_if #(.DATA_W(16), .REG_W(3)) bus ();

  wb_stage #(.DATA_W(16), .REG_W(3), .CNT_W(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .fwd_valid    (fwd_valid),
    .fwd_reg      (fwd_reg),
    .fwd_data     (fwd_data),
    .busy         (busy),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] exp_cnt();
    return 32'(exp_count % 16);
  endfunction

  task automatic drop_inputs();
    bus.in_valid        = 1'b0;
    bus.in_reg_write    = 1'($urandom_range(0, 1));
    bus.in_mem_to_reg   = 1'($urandom_range(0, 1));
    bus.in_dest         = 3'($urandom);
    bus.in_alu_result   = 16'($urandom);
    bus.mem_rdata       = 16'($urandom);
    bus.mem_rdata_valid = 1'b0;
  endtask

  // Idle cycles: mem_rdata_valid noise must be ignored, write port must hold.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drop_inputs();
      bus.mem_rdata_valid = 1'($urandom_range(0, 1));
      step();
      chk("idle_reg_write", 32'(reg_write), 32'd0);
      chk("idle_write_reg", 32'(write_reg), 32'(last_reg));
      chk("idle_write_data", 32'(write_data), 32'(last_data));
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_count", 32'(retired_count), exp_cnt());
    end
    bus.mem_rdata_valid = 1'b0;
  endtask

  // One instruction from acceptance through its commit cycle; returns while still in COMMIT.
  task automatic do_txn(input logic rw, input logic m2r, input logic [2:0] dest,
                        input logic [15:0] alu, input logic [15:0] rdata, input int delay);
    logic [15:0] d;
    d = m2r ? rdata : alu;
    bus.in_valid        = 1'b1;
    bus.in_reg_write    = rw;
    bus.in_mem_to_reg   = m2r;
    bus.in_dest         = dest;
    bus.in_alu_result   = alu;
    bus.mem_rdata       = ~rdata;
    bus.mem_rdata_valid = 1'($urandom_range(0, 1));
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    step();
    drop_inputs();
    if (m2r) begin
      for (int i = 0; i <= delay; i++) begin
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_in_ready", 32'(bus.in_ready), 32'd0);
        chk("wait_reg_write", 32'(reg_write), 32'd0);
        chk("wait_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("wait_fwd_reg", 32'(fwd_reg), 32'(dest));
        chk("wait_write_data", 32'(write_data), 32'(last_data));
        chk("wait_count", 32'(retired_count), exp_cnt());
        bus.in_valid = 1'($urandom_range(0, 1));
        if (i == delay) begin
          bus.mem_rdata_valid = 1'b1;
          bus.mem_rdata       = rdata;
        end
        step();
        drop_inputs();
      end
    end
    chk("commit_reg_write", 32'(reg_write), 32'(rw));
    chk("commit_write_reg", 32'(write_reg), 32'(dest));
    chk("commit_write_data", 32'(write_data), 32'(d));
    chk("commit_fwd_valid", 32'(fwd_valid), 32'(rw));
    chk("commit_fwd_reg", 32'(fwd_reg), 32'(dest));
    chk("commit_fwd_data", 32'(fwd_data), 32'(d));
    chk("commit_busy", 32'(busy), 32'd0);
    chk("commit_in_ready", 32'(bus.in_ready), 32'd1);
    chk("commit_count", 32'(retired_count), exp_cnt());
    exp_count++;
    last_reg  = dest;
    last_data = d;
  endtask

  initial begin
    drop_inputs();
    // Reset with in_valid asserted
    reset_n      = 1'b0;
    bus.in_valid = 1'b1;
    step();
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_count", 32'(retired_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_write_data", 32'(write_data), 32'd0);
    reset_n      = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Single ALU op
    do_txn(1'b1, 1'b0, 3'd3, 16'h1234, 16'h0000, 0);
    idle(1);
    chk("alu_count", 32'(retired_count), 32'd1);

    // Load with three busy cycles; ALU value 0xFFFF must not be written
    do_txn(1'b1, 1'b1, 3'd5, 16'hFFFF, 16'hBEEF, 2);
    idle(1);

    // Four back-to-back ALU ops
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid      = 1'b1;
      bus.in_reg_write  = 1'b1;
      bus.in_mem_to_reg = 1'b0;
      bus.in_dest       = 3'(i);
      bus.in_alu_result = 16'(i * 16);
      chk("b2b_ready", 32'(bus.in_ready), 32'd1);
      step();
      chk("b2b_reg_write", 32'(reg_write), 32'd1);
      chk("b2b_write_reg", 32'(write_reg), 32'(i));
      chk("b2b_write_data", 32'(write_data), 32'(i * 16));
      exp_count++;
      last_reg  = 3'(i);
      last_data = 16'(i * 16);
    end
    idle(1);
    chk("b2b_count", 32'(retired_count), 32'd6);

    // Fill to 15 then retire a non-writing op to wrap the 4-bit counter
    for (int i = 0; i < 9; i++) begin
      do_txn(1'b1, 1'b0, 3'($urandom), 16'($urandom), 16'h0, 0);
    end
    idle(1);
    chk("pre_wrap_count", 32'(retired_count), 32'd15);
    do_txn(1'b0, 1'b0, 3'd6, 16'hA5A5, 16'h0, 0);
    idle(1);
    chk("wrap_count", 32'(retired_count), 32'd0);

    // Reset while waiting on load data drops the load
    bus.in_valid      = 1'b1;
    bus.in_reg_write  = 1'b1;
    bus.in_mem_to_reg = 1'b1;
    bus.in_dest       = 3'd7;
    step();
    drop_inputs();
    chk("rw_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    step();
    reset_n   = 1'b1;
    exp_count = 0;
    last_reg  = '0;
    last_data = '0;
    bus.mem_rdata_valid = 1'b1;
    bus.mem_rdata       = 16'h5555;
    step();
    chk("rw_reg_write", 32'(reg_write), 32'd0);
    chk("rw_busy_after", 32'(busy), 32'd0);
    chk("rw_count", 32'(retired_count), 32'd0);
    idle(2);

    // Random transactions
    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom),
             16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)));
    end
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 16-bit pipeline. It is the producer side of the register-bank write port that the decode stage consumes.
- It accepts retiring instructions from the MEM stage over a valid/ready handshake and selects ALU result or load data.
- It waits on multi-cycle memory read data, then drives a single-cycle register write: RegWrite, destination register, data.
- It also drives forwarding info back to decode and a retired-instruction counter.

Parameters:
- DATA_W, 16, datapath width
- REG_W, 3, register address width
- CNT_W, 16, retired counter width

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_reg_write  in  1  instruction writes a register
- in_mem_to_reg  in  1  1 = result comes from memory load, 0 = from ALU
- in_dest  in  REG_W  destination register (already RegDst-resolved)
- in_alu_result  in  DATA_W  ALU result
- mem_rdata  in  DATA_W  load data
- mem_rdata_valid  in  1  load data valid strobe
- reg_write  out  1  register-bank write enable (RegWrite)
- write_reg  out  REG_W  register-bank write address
- write_data  out  DATA_W  register-bank write data (dataToWrite)
- fwd_valid  out  1  forwarding value valid
- fwd_reg  out  REG_W  forwarding destination
- fwd_data  out  DATA_W  forwarding value
- busy  out  1  waiting on load data; decode must stall dependents
- retired_count  out  CNT_W  retired instruction count

Behaviour:
- Reset (reset_n low at a rising edge): state=IDLE; reg_write, write_reg, write_data, fwd_*, busy, retired_count all 0. in_ready=0 while reset_n is low.
- Reset mid-WAIT_MEM drops the pending load: no write occurs and it is not counted.
- FSM states are IDLE, WAIT_MEM, COMMIT. A one-entry holding register stores reg_write, mem_to_reg, dest and data.
- in_ready = reset_n & (state != WAIT_MEM). A transfer occurs at a rising edge where in_valid & in_ready.
- IDLE or COMMIT with a transfer: capture the inputs. If in_mem_to_reg=0, data=in_alu_result and next=COMMIT. If in_mem_to_reg=1, next=WAIT_MEM.
- IDLE or COMMIT without a transfer: next=IDLE.
- WAIT_MEM: on a rising edge with mem_rdata_valid=1, data=mem_rdata and next=COMMIT; otherwise stay. mem_rdata_valid is ignored in every other state, including the acceptance edge itself.
- COMMIT lasts one cycle.
  - reg_write = held reg_write; write_reg = dest; write_data = data. All are registered outputs.
  - retired_count increments by 1 on the edge leaving COMMIT, wrapping from 2^CNT_W-1 to 0.
  - An instruction with reg_write=0 still passes through COMMIT with reg_write low and is counted.
- Outside COMMIT: reg_write=0. write_reg and write_data hold their last values.
- Latency:
  - ALU op accepted at edge k: reg_write high for exactly the cycle after edge k.
  - Load: reg_write high the cycle after the edge where mem_rdata_valid is sampled in WAIT_MEM.
- Throughput:
  - Back-to-back ALU ops: one per cycle, with reg_write continuously high.
  - Load: minimum 2 cycles (accept, then data edge).
- Forwarding:
  - fwd_valid = (state==COMMIT) & held reg_write; fwd_reg=dest; fwd_data=data.
  - In WAIT_MEM: fwd_valid=0, busy=1, fwd_reg=pending dest.
- Simultaneous transfer and COMMIT: the current commit completes; the new instruction occupies the holding register at the same edge.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> in_ready=0, reg_write=0, retired_count=0; release -> in_ready=1.
- ALU op: dest=3, alu=0x1234, reg_write=1, accepted at edge 1 -> reg_write=1, write_reg=3, write_data=0x1234 for one cycle; fwd_valid=1; retired_count=1.
- Load with 3-cycle memory delay: dest=5, mem_rdata=0xBEEF -> busy=1 and in_ready=0 for 3 cycles, then reg_write=1 with write_data=0xBEEF; an alu value of 0xFFFF is ignored.
- Back-to-back: 4 ALU ops in consecutive cycles (dests 1..4, data 0x10..0x40) -> 4 consecutive write cycles in order; retired_count=4.
- Non-writing op plus counter wrap: preload 0xFFFF retirements (or use CNT_W=4 with 15), then send in_reg_write=0 -> reg_write stays 0 and retired_count wraps to 0.
- Reset during WAIT_MEM, then mem_rdata_valid=1 -> no reg_write, retired_count unchanged.
